// File: rtl/enc_pkg.sv
//==============================================================================
// Module : enc_pkg
// Brief  : Shared types and constants for the 4-to-2 arbitrating encoder.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package enc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int N_REQ_DEF = 4;

    function automatic int idx_w_of(input int n);
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/enc_prio_sel.sv
//==============================================================================
// Module : enc_prio_sel
// Brief  : Combinational priority search; rotating from start_i, or fixed
//          highest-index-first when REVERSE is set (start_i unused then).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module enc_prio_sel #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter bit REVERSE = 1'b0
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int p;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        p       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (REVERSE) begin
                p = N_REQ - 1 - k;
            end else begin
                p = int'(start_i) + k;
                if (p >= N_REQ) p = p - N_REQ;
            end
            if (!found_o && req_i[p[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(p);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/encoder_4to2_arb.sv
//==============================================================================
// Module : encoder_4to2_arb
// Brief  : Sequential encoder latching request events into a pending set and
//          granting one index at a time over a valid/ready handshake.
//          Define ENC_RR_EN for round-robin priority (default: highest index).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module encoder_4to2_arb
    import enc_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_w_of(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    generate
        if (IDX_W != idx_w_of(N_REQ)) begin : g_idxw_bad
            $error("encoder_4to2_arb: IDX_W must equal $clog2(N_REQ)");
        end
    endgenerate

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic               hs;
    logic [N_REQ-1:0]   clr;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   sel_start;

    assign hs  = out_valid_q & out_ready;
    assign clr = hs ? (N_REQ'(1) << out_idx_q) : '0;

    // A fresh event on the bit being cleared re-arms it rather than overflowing.
    assign pending_d  = (pending_q & ~clr) | d;
    assign overflow_d = |(d & pending_q & ~clr);

`ifdef ENC_RR_EN
    logic [IDX_W-1:0] last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IDX_W'(N_REQ - 1);
        end else if (hs) begin
            last_q <= out_idx_q;
        end
    end

    assign sel_start = (last_q == IDX_W'(N_REQ - 1)) ? '0 : last_q + 1'b1;

    enc_prio_sel #(
        .N_REQ   (N_REQ),
        .IDX_W   (IDX_W),
        .REVERSE (1'b0)
    ) u_sel (
        .req_i   (pending_q),
        .start_i (sel_start),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );
`else
    assign sel_start = '0;

    enc_prio_sel #(
        .N_REQ   (N_REQ),
        .IDX_W   (IDX_W),
        .REVERSE (1'b1)
    ) u_sel (
        .req_i   (pending_q),
        .start_i (sel_start),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    out_idx_d   = sel_idx;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_4to2_arb.sv
//==============================================================================
// Module : tb_encoder_4to2_arb
// Brief  : Scoreboard bench for encoder_4to2_arb; directed vectors.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_encoder_4to2_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d = 4'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] pending;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int ovf_cnt = 0;
    int ovf0;
    int exp_q[$];

    encoder_4to2_arb u_dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL grant_unexpected: got idx %0d, expected no grant", out_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_idx) != e) begin
                    bad++;
                    $display("FAIL grant_idx: got %0d expected %0d", out_idx, e);
                end
            end
        end
        if (!rst && overflow) ovf_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; d = 4'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and single-request latency
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_ovf", overflow, 0);
        d = 4'b0100; out_ready = 1'b1; exp_q.push_back(2);
        tick(); d = 4'b0;
        chk("t1_pend_e1", pending, 4);
        chk("t1_valid_e1", out_valid, 0);
        tick();
        chk("t1_valid_e2", out_valid, 1);
        chk("t1_idx_e2", out_idx, 2);
        tick();
        chk("t1_valid_e3", out_valid, 0);
        chk("t1_pend_e3", pending, 0);
        drain("t1_drain", 10);

        // Multiple requests, one grant every two cycles
        do_reset();
        ovf0 = ovf_cnt;
`ifdef ENC_RR_EN
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
`else
        exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
`endif
        d = 4'b1011; out_ready = 1'b1;
        tick(); d = 4'b0;
        tick();
        chk("t2_valid_first", out_valid, 1);
        tick();
        chk("t2_gap", out_valid, 0);
        drain("t2_drain", 20);
        chk("t2_ovf", ovf_cnt - ovf0, 0);

        // Overflow while holding a grant
        do_reset();
        ovf0 = ovf_cnt;
        d = 4'b0001; out_ready = 1'b0;
        tick(); d = 4'b0;
        tick();
        chk("t3_valid", out_valid, 1);
        chk("t3_idx", out_idx, 0);
        tick(); d = 4'b0001;
        tick(); d = 4'b0;
        chk("t3_ovf_pulse", overflow, 1);
        chk("t3_idx_hold", out_idx, 0);
        tick();
        chk("t3_ovf_end", overflow, 0);
        chk("t3_valid_hold", out_valid, 1);
        exp_q.push_back(0); out_ready = 1'b1;
        drain("t3_drain", 10);
        chk("t3_pend_end", pending, 0);
        chk("t3_ovf_cnt", ovf_cnt - ovf0, 1);

        // No preemption by higher-priority arrival
        do_reset();
        ovf0 = ovf_cnt;
        d = 4'b0001; out_ready = 1'b0;
        tick(); d = 4'b0;
        tick(); d = 4'b1000;
        tick(); d = 4'b0;
        chk("t4_idx_hold", out_idx, 0);
        chk("t4_pend", pending, 9);
        exp_q.push_back(0); exp_q.push_back(3); out_ready = 1'b1;
        drain("t4_drain", 20);
        chk("t4_ovf", ovf_cnt - ovf0, 0);

        // New event on the granted bit in the handshake cycle
        do_reset();
        ovf0 = ovf_cnt;
        d = 4'b0010; out_ready = 1'b0;
        tick(); d = 4'b0;
        tick();
        chk("t5_idx", out_idx, 1);
        exp_q.push_back(1); exp_q.push_back(1);
        d = 4'b0010; out_ready = 1'b1;
        tick(); d = 4'b0;
        chk("t5_pend_kept", pending, 2);
        chk("t5_valid_gap", out_valid, 0);
        drain("t5_drain", 20);
        chk("t5_ovf", ovf_cnt - ovf0, 0);
        chk("t5_pend_end", pending, 0);

        // Reset during HOLD
        do_reset();
        d = 4'b0110; out_ready = 1'b0;
        tick(); d = 4'b0;
        tick();
        chk("t6_valid_pre", out_valid, 1);
        chk("t6_pend_pre", pending, 6);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("t6_valid", out_valid, 0);
        chk("t6_pend", pending, 0);
        chk("t6_idx", out_idx, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t6_valid_after", out_valid, 0);

`ifdef ENC_RR_EN
        // Round-robin ordering from reset
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        d = 4'b1111; out_ready = 1'b1;
        tick(); d = 4'b0;
        drain("t7_drain", 30);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
